// File: rtl/relay_encode.sv
// Oversampled serial transmitter: start '1', DATA_BITS MSB-first, optional even parity, then a low gap.
// Optional parity bit is compiled in with `define RELAY_ENCODE_PARITY_EN.
module relay_encode #(
  parameter int SAMPLES_PER_BIT = 64,
  parameter int DATA_BITS       = 8,
  parameter int GAP_BITS        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 data_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int SW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int GW = $clog2(GAP_BITS + 1);
  localparam logic [SW-1:0] CNT_LAST = SW'(SAMPLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef RELAY_ENCODE_PARITY_EN
    PARITY = 3'd3,
`endif
    GAP    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 data_out_q, data_out_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 bit_end;
`ifdef RELAY_ENCODE_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
`ifdef RELAY_ENCODE_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        gap_d = '0;
        if (tx_valid && tx_ready_q) begin
          shift_d = tx_data;
`ifdef RELAY_ENCODE_PARITY_EN
          parity_d = ^tx_data;
`endif
          state_d = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q << 1;
          if (bit_q == BIT_LAST) begin
`ifdef RELAY_ENCODE_PARITY_EN
            state_d = PARITY;
`else
            state_d = GAP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef RELAY_ENCODE_PARITY_EN
      PARITY: if (bit_end) state_d = GAP;
`endif
      GAP: begin
        if (bit_end) begin
          if (gap_q == GAP_LAST) state_d = IDLE;
          else gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so the line only moves at bit boundaries
    data_out_d = 1'b0;
    case (state_d)
      START:  data_out_d = 1'b1;
      DATA:   data_out_d = shift_d[DATA_BITS-1];
`ifdef RELAY_ENCODE_PARITY_EN
      PARITY: data_out_d = parity_d;
`endif
      default: data_out_d = 1'b0;
    endcase
    tx_ready_d   = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == GAP) && (gap_d == GAP_LAST) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      shift_q      <= '0;
`ifdef RELAY_ENCODE_PARITY_EN
      parity_q     <= 1'b0;
`endif
      data_out_q   <= 1'b0;
      tx_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      shift_q      <= shift_d;
`ifdef RELAY_ENCODE_PARITY_EN
      parity_q     <= parity_d;
`endif
      data_out_q   <= data_out_d;
      tx_ready_q   <= tx_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_out   = data_out_q;
  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relay_encode.sv
// Scoreboard bench for relay_encode: default instance plus a small SAMPLES_PER_BIT=2/DATA_BITS=4/GAP_BITS=1 instance.
module tb_relay_encode;

`ifdef RELAY_ENCODE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, data_out, busy, frame_done;
  logic [3:0] tx_data_s = '0;
  logic       tx_valid_s = 1'b0;
  logic       tx_ready_s, data_out_s, busy_s, frame_done_s;

  int n_cmp = 0;
  int n_bad = 0;
  // each entry: {busy, frame_done, data_out}
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  relay_encode u_dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .data_out(data_out), .busy(busy), .frame_done(frame_done)
  );

  relay_encode #(.SAMPLES_PER_BIT(2), .DATA_BITS(4), .GAP_BITS(1)) u_small (
    .clk(clk), .reset(reset), .tx_data(tx_data_s), .tx_valid(tx_valid_s),
    .tx_ready(tx_ready_s), .data_out(data_out_s), .busy(busy_s), .frame_done(frame_done_s)
  );

  task automatic push_frame(input logic [15:0] d, input int spb, input int db, input int gb);
    logic p;
    p = 1'b0;
    for (int i = 0; i < spb; i++) exp_q.push_back(3'b101);
    for (int b = db - 1; b >= 0; b--) begin
      p = p ^ d[b];
      for (int i = 0; i < spb; i++) exp_q.push_back({1'b1, 1'b0, d[b]});
    end
    if (PAR) for (int i = 0; i < spb; i++) exp_q.push_back({1'b1, 1'b0, p});
    for (int i = 0; i < gb * spb; i++) exp_q.push_back((i == gb * spb - 1) ? 3'b110 : 3'b100);
  endtask

  task automatic test_reset();
    tx_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, frame_done, data_out, tx_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_state got=%b want=0001", {busy, frame_done, data_out, tx_ready});
    end
    n_cmp++;
    if ({busy_s, frame_done_s, data_out_s, tx_ready_s} !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_state_small got=%b want=0001", {busy_s, frame_done_s, data_out_s, tx_ready_s});
    end
    reset = 1'b0;
    @(negedge clk);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (150) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_prebusy got=%b want=1", busy);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, frame_done, data_out, tx_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_async got=%b want=0001", {busy, frame_done, data_out, tx_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, data_out, tx_ready} !== 3'b001) begin
        n_bad++;
        $display("FAIL reset_no_resume cyc=%0d got=%b want=001", c, {busy, data_out, tx_ready});
      end
    end
  endtask

  task automatic test_single(input logic [7:0] d, input string nm);
    int n;
    exp_q.delete();
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    push_frame({8'h00, d}, 64, 8, 2);
    exp_q.push_back(3'b000);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      logic [2:0] e;
      @(negedge clk);
      tx_valid = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({busy, frame_done, data_out, tx_ready} !== {e, ~e[2]}) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%b want=%b", nm, c, {busy, frame_done, data_out, tx_ready}, {e, ~e[2]});
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, n1;
    exp_q.delete();
    @(negedge clk);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    push_frame(16'h00FF, 64, 8, 2);
    exp_q.push_back(3'b000);
    n1 = exp_q.size();
    push_frame(16'h0000, 64, 8, 2);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b000);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      logic [2:0] e;
      @(negedge clk);
      if (c == 0) tx_data = 8'h00;
      if (c == n1) tx_valid = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({busy, frame_done, data_out, tx_ready} !== {e, ~e[2]}) begin
        n_bad++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", c, {busy, frame_done, data_out, tx_ready}, {e, ~e[2]});
      end
    end
  endtask

  task automatic test_ignored();
    int n;
    exp_q.delete();
    @(negedge clk);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    push_frame(16'h003C, 64, 8, 2);
    repeat (3) exp_q.push_back(3'b000);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      logic [2:0] e;
      @(negedge clk);
      tx_valid = (c == 100);
      if (c == 0) tx_data = 8'hC3;
      e = exp_q.pop_front();
      n_cmp++;
      if ({busy, frame_done, data_out, tx_ready} !== {e, ~e[2]}) begin
        n_bad++;
        $display("FAIL ignored_input cyc=%0d got=%b want=%b", c, {busy, frame_done, data_out, tx_ready}, {e, ~e[2]});
      end
    end
  endtask

  task automatic test_sweep();
    int n;
    exp_q.delete();
    @(negedge clk);
    tx_data_s = 4'b1001;
    tx_valid_s = 1'b1;
    push_frame(16'h0009, 2, 4, 1);
    n = exp_q.size();
    n_cmp++;
    if (n !== (PAR ? 14 : 12)) begin
      n_bad++;
      $display("FAIL sweep_len model=%0d want=%0d", n, PAR ? 14 : 12);
    end
    exp_q.push_back(3'b000);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      logic [2:0] e;
      @(negedge clk);
      tx_valid_s = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({busy_s, frame_done_s, data_out_s, tx_ready_s} !== {e, ~e[2]}) begin
        n_bad++;
        $display("FAIL sweep cyc=%0d got=%b want=%b", c, {busy_s, frame_done_s, data_out_s, tx_ready_s}, {e, ~e[2]});
      end
    end
  endtask

`ifdef RELAY_ENCODE_PARITY_EN
  task automatic test_parity(input logic [7:0] d, input logic pbit);
    int n;
    exp_q.delete();
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    push_frame({8'h00, d}, 64, 8, 2);
    exp_q.push_back(3'b000);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      logic [2:0] e;
      @(negedge clk);
      tx_valid = 1'b0;
      e = exp_q.pop_front();
      if (c >= 576 && c < 640) e[0] = pbit;
      n_cmp++;
      if ({busy, frame_done, data_out, tx_ready} !== {e, ~e[2]}) begin
        n_bad++;
        $display("FAIL parity cyc=%0d got=%b want=%b", c, {busy, frame_done, data_out, tx_ready}, {e, ~e[2]});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single(8'hA5, "single_A5");
    test_back_to_back();
    test_ignored();
    test_sweep();
`ifdef RELAY_ENCODE_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/relay_encode.md
Name: relay_encode

Overview:
- Transmit-side serializer for the relay link.
- Accepts one parallel byte per handshake and emits it as an oversampled serial stream: one start bit, then data bits MSB-first, then an idle gap.
- Each bit is held for SAMPLES_PER_BIT clocks, so a receiver taking a majority vote over that many samples recovers the bit.
- The leading start '1' arms the receiver's "receiving" qualifier.

Parameters:
- SAMPLES_PER_BIT, 64, clocks per serial bit; legal range 2..128.
- DATA_BITS, 8, data bits per frame; legal range 1..16.
- GAP_BITS, 2, bit-times of forced-low output after each frame; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to send; sampled on accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a frame; registered.
- data_out  output  1  oversampled serial line to the link; registered.
- busy  output  1  frame or gap in progress (state != IDLE); registered.
- frame_done  output  1  one-cycle pulse on the last cycle of the gap.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE, data_out=0, tx_ready=1, busy=0, frame_done=0.
  - Sample counter, bit counter and shift register cleared.
- Reset mid-frame aborts the frame immediately. No partial frame resumes after reset is released.
- States: IDLE, START, DATA, PARITY (optional feature only), GAP.
- IDLE: data_out=0, tx_ready=1.
  - Accept = tx_valid & tx_ready on a rising edge: latch tx_data into the shift register, go to START, tx_ready=0, busy=1.
- START: data_out=1 for exactly SAMPLES_PER_BIT cycles. data_out rises on the first cycle after the accept edge (latency 1).
- DATA: data_out = shift_reg[MSB] for SAMPLES_PER_BIT cycles per bit.
  - Shift left by one at each bit boundary.
  - Bit counter runs 0..DATA_BITS-1; after the last bit go to PARITY if enabled, otherwise GAP.
- GAP: data_out=0 for GAP_BITS*SAMPLES_PER_BIT cycles. frame_done=1 on the final cycle only.
  - Next cycle: IDLE with tx_ready=1, busy=0.
- Sample counter:
  - Width clog2(SAMPLES_PER_BIT).
  - Counts 0..SAMPLES_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Never exceeds the terminal value.
- Gap counter: counts bit-times, width clog2(GAP_BITS+1).
- Frame length, default parameters, no parity: (1+8+2)*64 = 704 cycles from the first start-bit cycle to the last gap cycle.
- Back-to-back: tx_valid held high is accepted in the first IDLE cycle after GAP. Minimum accept-to-accept interval is frame length + 1 cycle.
- While tx_ready=0, tx_valid and tx_data are ignored; a changing tx_data never alters a frame in flight.
- data_out is glitch-free: changes only at bit boundaries.

Optional Feature:
- Macro: RELAY_ENCODE_PARITY_EN.
- Defined: after DATA, state PARITY drives one bit-time of even parity (XOR of the DATA_BITS latched bits).
  - Frame length becomes (1+DATA_BITS+1+GAP_BITS)*SAMPLES_PER_BIT; 768 cycles at defaults.
- Undefined: the PARITY state and parity logic are absent; DATA goes directly to GAP.

Test Plan:
- Reset values: assert reset asynchronously between clock edges mid-DATA, tx_data=8'hA5 -> data_out=0, tx_ready=1, busy=0 immediately, before any clock edge; after release the line stays 0 with no resumed bits.
- Single frame: tx_data=8'hA5, one-cycle tx_valid -> data_out=1 for 64 cycles (start), then 1,0,1,0,0,1,0,1 each 64 cycles, then 0 for 128 cycles; frame_done pulses at cycle 704; tx_ready returns next cycle.
- Back-to-back: tx_valid held with 8'hFF then 8'h00 -> second start bit begins exactly 1 idle cycle after the first frame_done; the second frame's data is all zeros for 512 cycles.
- Ignored input: change tx_data from 8'h3C to 8'hC3 and pulse tx_valid during the first frame -> only 8'h3C is serialized; no second frame is queued.
- Parameter sweep: SAMPLES_PER_BIT=2, DATA_BITS=4, GAP_BITS=1, tx_data=4'b1001 -> line sequence 11 11 00 00 11 00; frame length 12 cycles.
- Parity (RELAY_ENCODE_PARITY_EN defined): tx_data=8'h07 -> parity bit 1 held 64 cycles before the gap; tx_data=8'h03 -> parity bit 0; frame length 768 cycles.
